// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of D/E/M hazard inputs and stall/flush/MDU outputs for pipe_hazard_ctrl.
// master = pipeline side driving the hazard inputs, slave = the controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 4
);
  logic [4:0]       rs_D;
  logic [4:0]       rt_D;
  logic [1:0]       tuse_rs_D;
  logic [1:0]       tuse_rt_D;
  logic [4:0]       waddr_E;
  logic [1:0]       tnew_E;
  logic [4:0]       waddr_M;
  logic [1:0]       tnew_M;
  logic             md_start_E;
  logic             md_is_div_E;
  logic             md_use_D;
  logic             stall_F;
  logic             stall_D;
  logic             flush_E;
  logic             md_busy;
  logic [CNT_W-1:0] md_count;
  logic [31:0]      stall_cycles;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, waddr_E, tnew_E, waddr_M, tnew_M,
    output md_start_E, md_is_div_E, md_use_D,
    input  stall_F, stall_D, flush_E, md_busy, md_count, stall_cycles
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, waddr_E, tnew_E, waddr_M, tnew_M,
    input  md_start_E, md_is_div_E, md_use_D,
    output stall_F, stall_D, flush_E, md_busy, md_count, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with the MDU busy countdown.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  initial begin
    if (MULT_CYCLES < 1 || MULT_CYCLES > CNT_MAX)
      $error("pipe_hazard_ctrl: MULT_CYCLES=%0d does not fit CNT_W=%0d", MULT_CYCLES, CNT_W);
    if (DIV_CYCLES < 1 || DIV_CYCLES > CNT_MAX)
      $error("pipe_hazard_ctrl: DIV_CYCLES=%0d does not fit CNT_W=%0d", DIV_CYCLES, CNT_W);
  end

  logic [CNT_W-1:0] r_md_count;
  logic             w_md_busy;
  logic             w_rs_haz;
  logic             w_rt_haz;
  logic             w_md_haz;
  logic             w_stall;

  assign w_md_busy = (r_md_count != {CNT_W{1'b0}});

  // Register 0 is never a producer, so a zero source address cannot hazard.
  assign w_rs_haz = (bus.rs_D != 5'd0) &&
                    (((bus.rs_D == bus.waddr_E) && (bus.tuse_rs_D < bus.tnew_E)) ||
                     ((bus.rs_D == bus.waddr_M) && (bus.tuse_rs_D < bus.tnew_M)));
  assign w_rt_haz = (bus.rt_D != 5'd0) &&
                    (((bus.rt_D == bus.waddr_E) && (bus.tuse_rt_D < bus.tnew_E)) ||
                     ((bus.rt_D == bus.waddr_M) && (bus.tuse_rt_D < bus.tnew_M)));
  assign w_md_haz = bus.md_use_D & (w_md_busy | bus.md_start_E);
  assign w_stall  = w_rs_haz | w_rt_haz | w_md_haz;

  assign bus.stall_F  = w_stall & ~i_reset;
  assign bus.stall_D  = w_stall & ~i_reset;
  assign bus.flush_E  = w_stall & ~i_reset;
  assign bus.md_busy  = w_md_busy;
  assign bus.md_count = r_md_count;

  // A start while busy is ignored: no reload, no extension.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_md_count <= {CNT_W{1'b0}};
    end else if (bus.md_start_E && !w_md_busy) begin
      r_md_count <= bus.md_is_div_E ? DIV_LD : MULT_LD;
    end else if (w_md_busy) begin
      r_md_count <= r_md_count - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_md_count <= r_md_count;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  // Free-running stall counter, wraps naturally at 32 bits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cycles <= 32'h0;
    end else if (w_stall) begin
      r_stall_cycles <= r_stall_cycles + 32'h1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: table of register-hazard vectors plus
// hand-written MDU multiply/divide/reset sequences.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic i_clk;
  logic i_reset;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] wa_e;
    logic [1:0] tn_e;
    logic [4:0] wa_m;
    logic [1:0] tn_m;
    logic       md_use;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, ".stall_F"}, {31'd0, bus.stall_F}, {31'd0, exp});
    chk({name, ".stall_D"}, {31'd0, bus.stall_D}, {31'd0, exp});
    chk({name, ".flush_E"}, {31'd0, bus.flush_E}, {31'd0, exp});
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rs_D = 5'd0;        bus.rt_D = 5'd0;
    bus.tuse_rs_D = 2'd0;   bus.tuse_rt_D = 2'd0;
    bus.waddr_E = 5'd0;     bus.tnew_E = 2'd0;
    bus.waddr_M = 5'd0;     bus.tnew_M = 2'd0;
    bus.md_start_E = 1'b0;  bus.md_is_div_E = 1'b0;
    bus.md_use_D = 1'b0;
  endtask

  logic [31:0] exp_sc;

  initial begin
    checks = 0;
    errors = 0;
    i_clk = 1'b0;
    i_reset = 1'b1;
    clear_inputs();

    //           rs     rt     trs   trt   waE    tnE   waM    tnM  use stall
    vecs[0]  = '{5'd5,  5'd0,  2'd0, 2'd3, 5'd5,  2'd2, 5'd0,  2'd0, 1'b0, 1'b1};
    vecs[1]  = '{5'd5,  5'd0,  2'd0, 2'd3, 5'd5,  2'd0, 5'd0,  2'd0, 1'b0, 1'b0};
    vecs[2]  = '{5'd0,  5'd0,  2'd0, 2'd0, 5'd0,  2'd2, 5'd0,  2'd2, 1'b0, 1'b0};
    vecs[3]  = '{5'd0,  5'd7,  2'd0, 2'd0, 5'd0,  2'd0, 5'd7,  2'd1, 1'b0, 1'b1};
    vecs[4]  = '{5'd0,  5'd7,  2'd0, 2'd1, 5'd0,  2'd0, 5'd7,  2'd1, 1'b0, 1'b0};
    vecs[5]  = '{5'd3,  5'd0,  2'd1, 2'd0, 5'd3,  2'd2, 5'd0,  2'd0, 1'b0, 1'b1};
    vecs[6]  = '{5'd3,  5'd0,  2'd2, 2'd0, 5'd3,  2'd2, 5'd0,  2'd0, 1'b0, 1'b0};
    vecs[7]  = '{5'd9,  5'd0,  2'd1, 2'd0, 5'd8,  2'd2, 5'd9,  2'd2, 1'b0, 1'b1};
    vecs[8]  = '{5'd0,  5'd0,  2'd0, 2'd0, 5'd0,  2'd3, 5'd0,  2'd3, 1'b0, 1'b0};
    vecs[9]  = '{5'd1,  5'd2,  2'd0, 2'd0, 5'd3,  2'd3, 5'd4,  2'd3, 1'b1, 1'b0};
    vecs[10] = '{5'd31, 5'd0,  2'd2, 2'd0, 5'd31, 2'd3, 5'd0,  2'd0, 1'b0, 1'b1};
    vecs[11] = '{5'd0,  5'd4,  2'd0, 2'd1, 5'd4,  2'd1, 5'd0,  2'd0, 1'b0, 1'b0};

    // Reset state, with a live hazard on the inputs that must be masked.
    step();
    step();
    bus.rs_D = 5'd5; bus.waddr_E = 5'd5; bus.tnew_E = 2'd2;
    #1;
    chk_stall("reset_mask", 1'b0);
    chk("reset_count", {28'd0, bus.md_count}, 32'd0);
    chk("reset_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("reset_sc", bus.stall_cycles, 32'd0);
    clear_inputs();
    i_reset = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      bus.rs_D = vecs[i].rs;           bus.rt_D = vecs[i].rt;
      bus.tuse_rs_D = vecs[i].tuse_rs; bus.tuse_rt_D = vecs[i].tuse_rt;
      bus.waddr_E = vecs[i].wa_e;      bus.tnew_E = vecs[i].tn_e;
      bus.waddr_M = vecs[i].wa_m;      bus.tnew_M = vecs[i].tn_m;
      bus.md_use_D = vecs[i].md_use;
      #1;
      chk_stall($sformatf("vec%0d", i), vecs[i].exp_stall);
      step();
    end

    // Re-reset so the stall counter starts from zero for the multiply run.
    clear_inputs();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    #1;
    chk("rereset_sc", bus.stall_cycles, 32'd0);

    // Multiply with an MDU consumer held in D.
    bus.md_use_D = 1'b1;
    bus.md_start_E = 1'b1;
    bus.md_is_div_E = 1'b0;
    #1;
    chk_stall("mul_N", 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step();
      bus.md_start_E = 1'b0;
      #1;
      chk($sformatf("mul_cnt_N+%0d", k), {28'd0, bus.md_count}, 32'(6 - k));
      chk($sformatf("mul_busy_N+%0d", k), {31'd0, bus.md_busy}, (k <= 5) ? 32'd1 : 32'd0);
      chk_stall($sformatf("mul_N+%0d", k), (k <= 5) ? 1'b1 : 1'b0);
    end
`ifdef HAZARD_STALL_CNT_EN
    exp_sc = 32'd6;
`else
    exp_sc = 32'd0;
`endif
    step();
    chk("mul_stall_cycles", bus.stall_cycles, exp_sc);
    bus.md_use_D = 1'b0;

    // Divide, then a second start while busy must not reload.
    bus.md_start_E = 1'b1;
    bus.md_is_div_E = 1'b1;
    step();
    bus.md_start_E = 1'b0;
    #1;
    chk("div_load", {28'd0, bus.md_count}, 32'd10);
    for (int k = 0; k < 4; k++) step();
    chk("div_at6", {28'd0, bus.md_count}, 32'd6);
    bus.md_start_E = 1'b1;
    bus.md_is_div_E = 1'b0;
    step();
    bus.md_start_E = 1'b0;
    #1;
    chk("div_no_reload", {28'd0, bus.md_count}, 32'd5);
    step();
    chk("div_at4", {28'd0, bus.md_count}, 32'd4);

    // Reset mid-divide with an MDU consumer that would otherwise stall.
    bus.md_use_D = 1'b1;
    #1;
    chk_stall("div_busy_stall", 1'b1);
    i_reset = 1'b1;
    #1;
    chk_stall("rst_mid_mask", 1'b0);
    step();
    chk("rst_mid_count", {28'd0, bus.md_count}, 32'd0);
    chk("rst_mid_busy", {31'd0, bus.md_busy}, 32'd0);
    chk_stall("rst_mid_hold", 1'b0);
    i_reset = 1'b0;
    #1;
    chk_stall("post_rst", 1'b0);
    chk("post_rst_sc", bus.stall_cycles, 32'd0);
    step();
    chk("post_rst_busy", {31'd0, bus.md_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline.
- Decides when the F/D pipeline registers hold and when the D/E register is cleared to insert a bubble.
- Owns the multi-cycle multiply/divide busy counter, so mfhi/mflo/mult/div/mthi/mtlo in D wait for the MDU.
- Drives the stall input of the F and D pipeline registers, and the synchronous clear of the E pipeline register (ORed with global reset).

Parameters:
MULT_CYCLES, 5, busy cycles loaded on a multiply start (1..15)
DIV_CYCLES, 10, busy cycles loaded on a divide start (1..15)
CNT_W, 4, width of the MDU countdown counter

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
rs_D  in  5  D-stage source register 1 address
rt_D  in  5  D-stage source register 2 address
tuse_rs_D  in  2  cycles until rs value needed (0 = needed in D)
tuse_rt_D  in  2  cycles until rt value needed
waddr_E  in  5  E-stage destination register (0 = none)
tnew_E  in  2  cycles until E result available
waddr_M  in  5  M-stage destination register (0 = none)
tnew_M  in  2  cycles until M result available
md_start_E  in  1  E-stage instruction starts mult/div this cycle
md_is_div_E  in  1  1 = divide, 0 = multiply (valid with md_start_E)
md_use_D  in  1  D-stage instruction is an MDU instruction
stall_F  out  1  hold the F register (PC/IF-ID)
stall_D  out  1  hold the D register
flush_E  out  1  clear the E register to zero next edge (bubble)
md_busy  out  1  MDU counter nonzero
md_count  out  CNT_W  remaining MDU busy cycles
stall_cycles  out  32  stall-cycle counter (optional feature)

Behaviour:
- Reset (synchronous): md_count=0, md_busy=0, stall_cycles=0. While reset is high, stall_F=stall_D=flush_E=0 regardless of inputs.
- rs hazard (combinational):
  - rs_D!=0, and either rs_D==waddr_E with tuse_rs_D<tnew_E, or rs_D==waddr_M with tuse_rs_D<tnew_M.
  - Compare as unsigned.
- rt hazard: same rule using rt_D and tuse_rt_D.
- Register 0 never causes a hazard, even if waddr_E/waddr_M equals 0.
- MDU hazard: md_use_D & (md_busy | md_start_E).
- stall = rs hazard | rt hazard | MDU hazard.
- Output mapping: stall_F = stall_D = flush_E = stall. All three are combinational, with zero-cycle latency from inputs.
- Counter load: on a posedge with md_start_E=1 and md_busy=0, load md_count with DIV_CYCLES if md_is_div_E, else MULT_CYCLES.
- Counter decrement: otherwise, when md_count!=0, md_count decrements by 1 per cycle. It saturates at 0 and never wraps.
- md_start_E while md_busy=1 is ignored: the counter keeps counting, with no reload and no extension.
- md_busy = (md_count!=0), combinational from the register.
- Timing: md_start_E in cycle N → md_busy high in cycles N+1..N+MULT_CYCLES (or N+DIV_CYCLES for a divide). md_count shows 5,4,3,2,1, then 0.
- An MDU instruction in D stalls from cycle N until the first cycle with md_busy=0 and md_start_E=0.
- Simultaneous register and MDU hazards produce one stall; there is no priority issue because all outputs are identical.
- Reset mid-operation clears md_count to 0 on that edge. The first post-reset cycle has md_busy=0.
- Parameter values wider than CNT_W are an elaboration error. Add an initial-block check with $error.

Optional Feature:
Macro HAZARD_STALL_CNT_EN.
- Defined:
  - stall_cycles is a 32-bit register, cleared on reset.
  - It increments by 1 on every posedge where stall=1 and reset=0.
  - It wraps 0xFFFFFFFF→0.
- Undefined: stall_cycles is tied to 32'h0 and no counter flops are generated.

Test Plan:
1. Load-use: rs_D=5, tuse_rs_D=0, waddr_E=5, tnew_E=2 → stall_F=stall_D=flush_E=1. Then change to tnew_E=0 → all 0.
2. Zero register: rt_D=0, waddr_E=0, tnew_E=2, tuse_rt_D=0 → no stall. M-stage case rt_D=7, waddr_M=7, tnew_M=1, tuse_rt_D=0 → stall=1; with tuse_rt_D=1 → stall=0.
3. Multiply: md_start_E=1 (is_div=0) at cycle N, md_use_D=1 held →
   - md_count = 5,4,3,2,1,0 in cycles N+1..N+6.
   - stall=1 in cycles N..N+5, 0 at N+6.
4. Divide, then a second start while busy: md_start_E=1, is_div=1 → md_count=10. md_start_E=1 again while md_count=6 → next md_count=5 (no reload).
5. Reset mid-divide: assert reset when md_count=4 → next cycle md_count=0, md_busy=0, all stall outputs 0 during reset.
6. With HAZARD_STALL_CNT_EN: run scenario 3 → stall_cycles=6. Without the macro → stall_cycles=0 throughout.
